pll_lock_monitor: RTL and testbench

Lock-qualified reset sequencer running on the PLL output clock, placed directly behind the iCE40 PLL wrapper. It synchronizes the asynchronous `locked` flag, requires it to be stable for a programmable window, and stretches a reset hold time before releasing `rst_out` to the rest of the gateware. While running, it detects lock loss, re-asserts reset, and keeps a sticky flag and a saturating loss counter for the host interface.

---
 rtl/pll_lock_monitor_if.sv | 31 +++
 rtl/pll_lock_monitor.sv | 134 +++++++++++++
 tb/tb_pll_lock_monitor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_monitor_if.sv
// rtl/pll_lock_monitor_if.sv - lock monitor control/status bundle
interface pll_lock_monitor_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 locked;
    logic                 clear;
    logic                 rst_out;
    logic                 ready;
    logic                 lock_lost;
    logic [CNT_WIDTH-1:0] loss_count;

    // Host/PLL side: supplies the lock flag and clear, observes reset and status
    modport master (
        output locked,
        output clear,
        input  rst_out,
        input  ready,
        input  lock_lost,
        input  loss_count
    );

    // Monitor side
    modport slave (
        input  locked,
        input  clear,
        output rst_out,
        output ready,
        output lock_lost,
        output loss_count
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - lock-qualified reset sequencer with loss tracking
module pll_lock_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_WIDTH     = 8
) (
    input  logic              clock,
    input  logic              reset,
    pll_lock_monitor_if.slave mon
);
    // One counter serves both the stable window and the hold stretch
    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STABLE    = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          loss_event;

    logic                 rst_out_q;
    logic                 ready_q;
    logic                 lock_lost_q;
    logic [CNT_WIDTH-1:0] loss_count_q;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous PLL lock flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon.locked};
        end
    end

    // Qualification sequence: wait for lock, count stable window, stretch hold, run
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d    = ST_WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and the registered reset outputs (decoded from next state)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
        end
    end

    // Sticky loss flag and saturating loss counter; a loss outranks a same-cycle clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else if (loss_event) begin
            lock_lost_q <= 1'b1;
            if (mon.clear) begin
                loss_count_q <= CNT_WIDTH'(1);
            end else if (!(&loss_count_q)) begin
                loss_count_q <= loss_count_q + CNT_WIDTH'(1);
            end
        end else if (mon.clear) begin
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end
    end

    assign mon.rst_out    = rst_out_q;
    assign mon.ready      = ready_q;
    assign mon.lock_lost  = lock_lost_q;
    assign mon.loss_count = loss_count_q;
endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - self-checking bench for pll_lock_monitor
module tb_pll_lock_monitor;
    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int HOLD   = 4;
    localparam int CNTW   = 2;
    // Edges with synchronized lock high needed before release (entry edge + windows)
    localparam int THR    = 1 + STABLE + HOLD;
    localparam int CMAX   = (1 << CNTW) - 1;
    // Edges from the first edge that samples a rising locked to the release edge
    localparam int REL_EDGES  = SYNC + STABLE + HOLD + 1;
    localparam int LOSS_EDGES = SYNC + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int tests = 0;
    int fails = 0;

    pll_lock_monitor_if #(.CNT_WIDTH(CNTW)) mon_if ();

    pll_lock_monitor #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLD),
        .CNT_WIDTH    (CNTW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mon  (mon_if.slave)
    );

    always #5 clock = ~clock;

    // Reference model: lock history since reset, run length of synchronized lock
    bit lk_hist[$];
    int run_len;
    bit m_lost;
    int m_count;
    bit m_rst;

    task automatic model_reset();
        lk_hist.delete();
        run_len = 0;
        m_lost  = 1'b0;
        m_count = 0;
        m_rst   = 1'b1;
    endtask

    task automatic model_edge(input bit lk, input bit clr);
        bit ls;
        bit loss;
        ls = (lk_hist.size() >= SYNC) ? lk_hist[lk_hist.size() - SYNC] : 1'b0;
        lk_hist.push_back(lk);
        loss = !ls && (run_len >= THR);
        if (ls) run_len = (run_len < THR) ? run_len + 1 : THR;
        else    run_len = 0;
        m_rst = (run_len < THR);
        if (loss) begin
            m_lost  = 1'b1;
            m_count = clr ? 1 : ((m_count < CMAX) ? m_count + 1 : CMAX);
        end else if (clr) begin
            m_lost  = 1'b0;
            m_count = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("rst_out", {31'd0, mon_if.rst_out}, {31'd0, m_rst});
        check("ready", {31'd0, mon_if.ready}, {31'd0, !m_rst});
        check("lock_lost", {31'd0, mon_if.lock_lost}, {31'd0, m_lost});
        check("loss_count", {30'd0, mon_if.loss_count}, m_count);
    endtask

    // One clock: inputs were set at the preceding falling edge
    task automatic tick();
        bit lk;
        bit clr;
        lk  = mon_if.locked;
        clr = mon_if.clear;
        @(posedge clock);
        if (reset) model_reset();
        else       model_edge(lk, clr);
        @(negedge clock);
        check_all();
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (mon_if.ready !== 1'b1 && n < 60);
        check(tag, n, REL_EDGES);
    endtask

    task automatic wait_reassert(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (mon_if.rst_out !== 1'b1 && n < 20);
        check(tag, n, LOSS_EDGES);
    endtask

    initial begin
        mon_if.locked = 1'b0;
        mon_if.clear  = 1'b0;
        model_reset();

        // Reset values, applied with no clock edge
        #1 reset = 1'b1;
        #1 check_all();
        tick();
        tick();
        reset = 1'b0;

        // Clean lock
        repeat (3) tick();
        mon_if.locked = 1'b1;
        wait_release("clean_lock_edges");
        repeat (3) tick();

        // Reset mid-operation with locked held high
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        check("async_rst_out", {31'd0, mon_if.rst_out}, 32'd1);
        @(negedge clock);
        tick();
        reset = 1'b0;
        wait_release("reset_relock_edges");

        // Return to a clean state with lock low, then glitch during qualification
        mon_if.locked = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        @(negedge clock);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        mon_if.locked = 1'b1;
        repeat (6) tick();
        mon_if.locked = 1'b0;
        tick();
        mon_if.locked = 1'b1;
        wait_release("glitch_release_edges");
        check("glitch_lock_lost", {31'd0, mon_if.lock_lost}, 32'd0);
        check("glitch_loss_count", {30'd0, mon_if.loss_count}, 32'd0);

        // Loss in RUN, then relock; sticky flag survives
        repeat (2) tick();
        mon_if.locked = 1'b0;
        wait_reassert("loss_edges");
        check("loss_lock_lost", {31'd0, mon_if.lock_lost}, 32'd1);
        check("loss_count_1", {30'd0, mon_if.loss_count}, 32'd1);
        mon_if.locked = 1'b1;
        wait_release("relock_edges");
        check("relock_lock_lost", {31'd0, mon_if.lock_lost}, 32'd1);

        // Saturation: four more losses make five in total
        for (int i = 0; i < 4; i++) begin
            mon_if.locked = 1'b0;
            wait_reassert("sat_loss_edges");
            mon_if.locked = 1'b1;
            wait_release("sat_relock_edges");
        end
        check("sat_count", {30'd0, mon_if.loss_count}, CMAX);

        // Clear pulse
        mon_if.clear = 1'b1;
        tick();
        mon_if.clear = 1'b0;
        check("clear_count", {30'd0, mon_if.loss_count}, 32'd0);
        check("clear_lost", {31'd0, mon_if.lock_lost}, 32'd0);
        check("clear_keeps_ready", {31'd0, mon_if.ready}, 32'd1);

        // Clear on the same edge as a loss: loss wins
        mon_if.locked = 1'b0;
        tick();
        tick();
        mon_if.clear = 1'b1;
        tick();
        mon_if.clear = 1'b0;
        check("clr_loss_count", {30'd0, mon_if.loss_count}, 32'd1);
        check("clr_loss_lost", {31'd0, mon_if.lock_lost}, 32'd1);
        check("clr_loss_rst", {31'd0, mon_if.rst_out}, 32'd1);

        // Randomized lock runs and sparse clears against the model
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            mon_if.locked = ~mon_if.locked;
            len = (seg % 4 == 0) ? $urandom_range(14, 30) : $urandom_range(1, 18);
            for (int c = 0; c < len; c++) begin
                mon_if.clear = ($urandom_range(0, 15) == 0);
                tick();
            end
            mon_if.clear = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
